// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file constants, write-request type and one-hot helper
package regfile_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wr_req_t;

    // One-hot mask of a register address, used for the hazard mask.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] mask;
        mask       = '0;
        mask[addr] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// rtl/regfile_write_arbiter_rr_arbiter.sv - one-hot grant arbiter, round-robin or fixed priority (REGWR_ARB_FIXED_PRIO_EN)
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hold,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant
);

    // No grant may be issued while in reset or while the consumer holds us off.
    logic allow;
    assign allow = !rst && !hold;

`ifdef REGWR_ARB_FIXED_PRIO_EN

    logic found;

    // Lowest requesting index wins; there is no rotation state.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (allow && !found && req[i]) begin
                found    = 1'b1;
                grant[i] = 1'b1;
            end
        end
    end

`else

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SUM_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] gidx;
    logic [PTR_W-1:0] cand;
    logic [SUM_W-1:0] sum;
    logic             found;

    // Scan from ptr upward, wrapping modulo NUM_REQ; first valid requester wins.
    always_comb begin
        grant = '0;
        gidx  = ptr;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + SUM_W'(i);
            if (sum >= SUM_W'(NUM_REQ)) begin
                sum = sum - SUM_W'(NUM_REQ);
            end
            cand = sum[PTR_W-1:0];
            if (allow && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                gidx        = cand;
            end
        end
    end

    // Pointer moves just past the winner; it holds when nobody is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (gidx == LAST) ? '0 : gidx + 1'b1;
        end
    end

`endif

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the register-file write port between requesters; REGWR_ARB_FIXED_PRIO_EN selects fixed priority
import regfile_pkg::*;

module regfile_write_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int CNT_W   = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          hold,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd,
    input  logic [NUM_REQ*XLEN-1:0]       req_data,
    output logic                          RegWrite,
    output logic [REG_ADDR_W-1:0]         WriteReg,
    output logic [XLEN-1:0]               WriteData,
    output logic [NUM_REGS-1:0]           pending_mask,
    output logic [CNT_W-1:0]              commit_count,
    output logic [CNT_W-1:0]              drop_count
);

    logic [NUM_REQ-1:0] grant;
    wr_req_t            sel;
    logic               xfer;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .hold  (hold),
        .req   (req_valid),
        .grant (grant)
    );

    // The arbiter only grants valid requesters, so a grant is a transfer.
    assign req_ready = grant;
    assign xfer      = |grant;

    // Select the granted requester's destination and data from the one-hot grant.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel.rd   = req_rd[i*REG_ADDR_W +: REG_ADDR_W];
                sel.data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    // Hazard logic sees the register currently being written, nothing otherwise.
    assign pending_mask = RegWrite ? reg_onehot(WriteReg) : '0;

    // One-entry output register plus commit/drop accounting; x0 writes are swallowed.
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite     <= 1'b0;
            WriteReg     <= '0;
            WriteData    <= '0;
            commit_count <= '0;
            drop_count   <= '0;
        end else begin
            if (xfer) begin
                WriteReg  <= sel.rd;
                WriteData <= sel.data;
                RegWrite  <= (sel.rd != ZERO_REG);
                if (sel.rd == ZERO_REG) begin
                    drop_count <= drop_count + CNT_W'(1);
                end
            end else begin
                RegWrite <= 1'b0;
            end
            if (RegWrite) begin
                commit_count <= commit_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - randomized self-checking bench with behavioural model for regfile_write_arbiter
module tb_regfile_write_arbiter;

    localparam int N  = 2;
    localparam int CW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              hold;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [4:0]        rd_a   [N];
    logic [63:0]       data_a [N];
    logic [N*5-1:0]    req_rd;
    logic [N*64-1:0]   req_data;
    logic              RegWrite;
    logic [4:0]        WriteReg;
    logic [63:0]       WriteData;
    logic [31:0]       pending_mask;
    logic [CW-1:0]     commit_count;
    logic [CW-1:0]     drop_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign req_rd[5*gi +: 5]    = rd_a[gi];
        assign req_data[64*gi +: 64] = data_a[gi];
    end

    regfile_write_arbiter #(
        .NUM_REQ (N),
        .CNT_W   (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .hold         (hold),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rd       (req_rd),
        .req_data     (req_data),
        .RegWrite     (RegWrite),
        .WriteReg     (WriteReg),
        .WriteData    (WriteData),
        .pending_mask (pending_mask),
        .commit_count (commit_count),
        .drop_count   (drop_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: what the outputs must be after the most recent clock edge.
    bit            m_live = 1'b0;
    int            m_ptr;
    bit            m_we;
    int            m_wreg;
    logic [63:0]   m_wdata;
    logic [CW-1:0] m_commit;
    logic [CW-1:0] m_drop;
    logic [63:0]   m_regs [32];

    function automatic int pick(input logic [N-1:0] v, input bit h, input bit r, input int p);
        int j;
        if (r || h) return -1;
        for (int k = 0; k < N; k++) begin
`ifdef REGWR_ARB_FIXED_PRIO_EN
            j = k;
`else
            j = (p + k) % N;
`endif
            if (v[j]) return j;
        end
        return -1;
    endfunction

    // Compare outputs against the model each negedge, then advance the model to the next edge.
    initial begin
        int g;
        logic [N-1:0] e;
        forever begin
            @(negedge clk);
            g = pick(req_valid, hold, rst, m_ptr);
            if (m_live) begin
                e = '0;
                if (g >= 0) e[g] = 1'b1;
                chk("cmp_ready", req_ready, e);
                chk("cmp_regwrite", RegWrite, m_we);
                chk("cmp_writereg", WriteReg, m_wreg);
                chk("cmp_writedata", WriteData, m_wdata);
                chk("cmp_pending", pending_mask, m_we ? (64'd1 << m_wreg) : 64'd0);
                chk("cmp_commit", commit_count, m_commit);
                chk("cmp_drop", drop_count, m_drop);
            end
            if (rst) begin
                m_live = 1'b1;
                m_ptr = 0; m_we = 1'b0; m_wreg = 0; m_wdata = '0;
                m_commit = '0; m_drop = '0;
            end else if (m_live) begin
                if (m_we) begin
                    m_regs[m_wreg] = m_wdata;
                    m_commit = m_commit + 1'b1;
                end
                if (g >= 0) begin
                    m_wreg  = rd_a[g];
                    m_wdata = data_a[g];
                    m_we    = (rd_a[g] != 5'd0);
                    if (!m_we) m_drop = m_drop + 1'b1;
                    m_ptr = (g + 1) % N;
                end else begin
                    m_we = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        hold = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    logic [N-1:0] exp_g [4];
    int           exp_w [4];

    initial begin
        rst = 1'b1; hold = 1'b0; req_valid = 2'b11;
        rd_a[0] = 5'd1; rd_a[1] = 5'd2;
        data_a[0] = 64'h11; data_a[1] = 64'h22;

        // Reset with both requesters valid
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_ready", req_ready, 0);
            chk("rst_regwrite", RegWrite, 0);
            chk("rst_pending", pending_mask, 0);
            chk("rst_commit", commit_count, 0);
            chk("rst_drop", drop_count, 0);
            tick();
        end

        // Single write
        rst = 1'b0; req_valid = 2'b01; rd_a[0] = 5'd5; data_a[0] = 64'hDEAD_BEEF;
        @(negedge clk); chk("single_ready", req_ready, 2'b01);
        tick(); req_valid = '0;
        @(negedge clk);
        chk("single_regwrite", RegWrite, 1);
        chk("single_writereg", WriteReg, 5);
        chk("single_writedata", WriteData, 64'hDEAD_BEEF);
        chk("single_pending", pending_mask, 32'h20);
        tick();
        @(negedge clk);
        chk("single_commit", commit_count, 1);
        chk("single_regwrite_off", RegWrite, 0);
        tick();

        // Contention from reset
`ifdef REGWR_ARB_FIXED_PRIO_EN
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
        exp_w = '{1, 1, 1, 1};
`else
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_w = '{1, 2, 1, 2};
`endif
        do_reset();
        rd_a[0] = 5'd1; rd_a[1] = 5'd2;
        for (int c = 0; c < 5; c++) begin
            req_valid = (c < 4) ? 2'b11 : 2'b00;
            @(negedge clk);
            if (c < 4) chk("contend_grant", req_ready, exp_g[c]);
            if (c >= 1) chk("contend_writereg", WriteReg, exp_w[c-1]);
            tick();
        end

        // x0 drop
        do_reset();
        req_valid = 2'b10; rd_a[1] = 5'd0; data_a[1] = 64'h1234;
        @(negedge clk); chk("x0_ready", req_ready, 2'b10);
        tick(); req_valid = '0;
        @(negedge clk);
        chk("x0_regwrite", RegWrite, 0);
        chk("x0_drop", drop_count, 1);
        chk("x0_commit", commit_count, 0);
        tick();

        // Same-rd race
        do_reset();
        req_valid = 2'b11; rd_a[0] = 5'd7; rd_a[1] = 5'd7;
        data_a[0] = 64'hAAAA; data_a[1] = 64'hBBBB;
        @(negedge clk); chk("race_ready0", req_ready, 2'b01);
        tick(); req_valid = 2'b10;
        @(negedge clk);
        chk("race_first_reg", WriteReg, 7);
        chk("race_first_data", WriteData, 64'hAAAA);
        chk("race_ready1", req_ready, 2'b10);
        tick(); req_valid = '0;
        @(negedge clk);
        chk("race_second_we", RegWrite, 1);
        chk("race_second_data", WriteData, 64'hBBBB);
        tick();
        @(negedge clk);
        chk("race_x7_final", m_regs[7], 64'hBBBB);
        chk("race_commit", commit_count, 2);
        tick();

        // hold right after an accept
        do_reset();
        req_valid = 2'b01; rd_a[0] = 5'd3; data_a[0] = 64'h33;
        @(negedge clk); chk("hold_accept", req_ready, 2'b01);
        tick(); hold = 1'b1; rd_a[0] = 5'd4;
        @(negedge clk);
        chk("hold_we", RegWrite, 1);
        chk("hold_reg", WriteReg, 3);
        chk("hold_ready", req_ready, 0);
        tick();
        @(negedge clk);
        chk("hold_we_off", RegWrite, 0);
        chk("hold_ready2", req_ready, 0);
        chk("hold_commit", commit_count, 1);
        tick(); hold = 1'b0;
        @(negedge clk); chk("hold_resume", req_ready, 2'b01);
        tick(); req_valid = '0;

        // reset on an accept cycle
        rst = 1'b1; req_valid = 2'b01; rd_a[0] = 5'd9;
        @(negedge clk); chk("rstacc_ready", req_ready, 0);
        tick(); rst = 1'b0; req_valid = '0;
        @(negedge clk);
        chk("rstacc_we", RegWrite, 0);
        chk("rstacc_commit", commit_count, 0);
        tick();

        // Randomized traffic, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            rst  = ($urandom_range(0, 49) == 0);
            hold = ($urandom_range(0, 9) == 0);
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                rd_a[i]   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
                data_a[i] = {$urandom, $urandom};
            end
            tick();
        end

        rst = 1'b0; hold = 1'b0; req_valid = '0;
        tick();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (RegWrite/WriteReg/WriteData) between NUM_REQ writeback sources, e.g. ALU result and load unit.
- Round-robin arbitration with a valid/ready handshake per requester.
- Drives the register file from a one-entry output register.
- Publishes a pending-write mask for hazard logic, plus commit and drop counters.

Parameters:
NUM_REQ, 2, number of write requesters (2..8)
CNT_W, 32, width of commit_count and drop_count

Ports:
clk  in  1  clock; everything updates on posedge
rst  in  1  synchronous, active-high reset
hold  in  1  blocks all grants while high
req_valid  in  NUM_REQ  per-requester write request
req_ready  out  NUM_REQ  per-requester grant; transfer when valid&ready
req_rd  in  NUM_REQ*5  destination register; requester i at [5i+4:5i]
req_data  in  NUM_REQ*64  write data; requester i at [64i+63:64i]
RegWrite  out  1  write enable to register file
WriteReg  out  5  register file write address
WriteData  out  64  register file write data
pending_mask  out  32  one-hot of WriteReg when RegWrite=1, else 0
commit_count  out  CNT_W  writes issued with RegWrite=1
drop_count  out  CNT_W  accepted writes targeting x0

Behaviour:
- Reset:
  - RegWrite=0, WriteReg=0, WriteData=0, pending_mask=0.
  - Counters=0, round-robin pointer=0.
  - req_ready=0 during any cycle with rst=1; a transfer in progress is discarded.
- Grant (combinational):
  - With hold=0, exactly one requester with req_valid=1 gets req_ready=1; all others 0.
  - With no valid requests, or hold=1, all req_ready=0.
  - req_ready depends on req_valid; requesters must not make req_valid depend on req_ready.
- Priority:
  - Search starts at pointer ptr and wraps modulo NUM_REQ.
  - After a grant to g, ptr <= (g+1) mod NUM_REQ.
  - Without a grant, ptr holds.
- Output stage:
  - A transfer in cycle N loads WriteReg=rd and WriteData=data in cycle N+1.
  - RegWrite=1 in cycle N+1 iff rd!=0.
  - The register file commits at the end of cycle N+1, so accept-to-commit latency is 2 edges.
  - With no transfer, RegWrite<=0; WriteReg and WriteData hold their last values.
  - The stage never back-pressures: one accept per cycle max, and the register file always accepts.
- x0:
  - rd==0 transfers are accepted normally.
  - RegWrite stays 0 and drop_count increments.
- Counters:
  - commit_count increments on every cycle with RegWrite=1.
  - Both counters wrap silently at 2^CNT_W.
- Same rd from two requesters in the same cycle: each is served in grant order, so the later grant's data is the final register value. Cross-requester ordering beyond that is the requesters' responsibility.
- hold:
  - Asserting hold mid-stream lets an already-registered write complete.
  - RegWrite falls the cycle after the last accept.
  - Deasserting hold resumes arbitration from the retained ptr.

Optional Feature:
- Macro: REGWR_ARB_FIXED_PRIO_EN.
  - Defined: fixed priority, lowest index wins, ptr removed; requester 0 can starve the others.
  - Undefined (default): round-robin as above.
  - Handshake, latency and counters are identical in both builds.

Decomposition:
- Package regfile_pkg holds:
  - XLEN=64, REG_ADDR_W=5, NUM_REGS=32.
  - ZERO_REG=5'd0.
  - A write-request struct {rd, data}.
- Sub-module rr_arbiter (NUM_REQ-wide, inputs request vector and hold, outputs one-hot grant, owns ptr) isolates arbitration; the macro selects its internals.
- The top level holds the output register, mask and counters.

Test Plan:
- Reset: rst=1 for 2 cycles with both req_valid=1 -> req_ready=0; RegWrite=0; pending_mask=0; both counters 0.
- Single write: cycle 0 req0 valid, rd=5, data=0xDEAD_BEEF -> req_ready[0]=1 in cycle 0; cycle 1 RegWrite=1, WriteReg=5, WriteData=0xDEADBEEF, pending_mask=0x20; commit_count=1 in cycle 2.
- Contention: both valid for 4 cycles from reset, rd0=1, rd1=2 -> grant sequence 0,1,0,1; WriteReg sequence 1,2,1,2 on cycles 1-4.
  - With REGWR_ARB_FIXED_PRIO_EN: grants 0,0,0,0.
- x0 drop: req1 rd=0, data=0x1234 -> accepted; RegWrite=0 next cycle; drop_count=1; commit_count unchanged.
- Same-rd race: req0 rd=7 data=A and req1 rd=7 data=B in the same cycle from reset -> cycle 1 writes A, cycle 2 writes B; x7 reads B afterwards.
- hold/reset mid-op: hold=1 the cycle after an accept -> that write still commits, then RegWrite=0 and no ready while hold=1. rst=1 on an accept cycle -> no write is issued.
